sfx_sequencer: RTL and testbench
================================

# sfx_sequencer

Multi-event sound-effect sequencer for the snake game audio path. It accepts one-cycle event requests from the game logic, such as wall hit, apple eaten or direction change. The highest-priority request selects a short fixed melody of up to four notes, and the block plays it as a square wave on the board PWM audio pin. It sits between the game FSM and the AUD_PWM/AUD_SD pins. It adds priority preemption, multi-note sequences and optional request queuing.

## Interface
- NUM_EVENTS, 8: number of request inputs; index 0 has the highest priority; legal range 2..16.
- STEP_CYC, 12_500_000: clk_in cycles per note step (125 ms at 100 MHz); must be ≥ 2.
- DIV_SHIFT, 0: right-shift applied to every half-period constant; a nonzero value is for simulation only.
- clk_in  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- ev_req  in  NUM_EVENTS  one-cycle request pulses; several bits may be high at once.
- aud_pwm  out  1  square-wave tone output.
- aud_sd  out  1  amplifier enable; high while a note is sounding.
- busy  out  1  high while a sequence is playing.
- cur_event  out  4  index of the event currently playing.
- done  out  1  one-cycle pulse when a sequence ends naturally, not when it is preempted.

## Operation
- The pitch codes use the following half-periods in clk_in cycles, each shifted right by DIV_SHIFT:
  - 1 = 95547
  - 2 = 85135
  - 3 = 75838
  - 4 = 71581
  - 5 = 63775
  - 6 = 56818
  - 7 = 50617
  - Code 0 means end of sequence.
- Fixed melody ROM, four steps per event:
  - ev0 (crash): 7,5,3,1
  - ev1 (apple): 5,6,0,0
  - ev2 (bonus): 5,6,7,7
  - ev3 (move): 1,0,0,0
  - ev4 and above: 1,0,0,0
- FSM states:
  - IDLE: aud_sd=0, busy=0, aud_pwm=0.
  - PLAY:
    - Loads the step's half-period.
    - A divider counts 0..HALF-1 and toggles aud_pwm on wrap.
    - A step counter counts 0..STEP_CYC-1.
  - NEXT:
    - Runs for one cycle.
    - Increments the step index.
    - Goes to IDLE with done=1 if the step index was 3 or the next code is 0; otherwise goes to PLAY.
- Arbitration:
  - The winner is the lowest set index of ev_req.
  - From IDLE, any request starts a sequence.
  - In PLAY or NEXT, a winner with index strictly lower than cur_event restarts immediately at step 0 of the new event. done is not pulsed.
  - Requests of equal or lower priority are dropped, unless SFX_QUEUE_EN is defined.
- Width rules:
  - Divider: 17 bits.
  - Step counter: $clog2(STEP_CYC) bits.
  - The index is clamped to 4 bits.
- At each note start, aud_pwm is forced to 0 and the divider to 0, so every note begins with a fresh phase.

## Timing
- All outputs reset to 0: aud_pwm, aud_sd, busy, cur_event, done.
- Reset is honoured mid-sequence. The sequence is lost, and any pending request is cleared.
- A request sampled high at edge N gives busy=1, aud_sd=1 and valid cur_event after edge N+1.
- The first aud_pwm rise occurs HALF cycles later.
- Each step lasts exactly STEP_CYC cycles in PLAY, plus 1 cycle in NEXT. aud_sd stays high through NEXT.
- done is asserted during the cycle after NEXT, coincident with busy falling.
- A request arriving in that same cycle starts a new sequence one cycle later. No request is lost.
- A preempting request takes effect one cycle after sampling. cur_event and the half-period change together.

## Configuration
- SFX_QUEUE_EN, when defined:
  - There is a one-entry pending register.
  - A dropped, non-preempting request is stored if the register is empty, or if it has higher priority than the stored entry.
  - On natural completion, the stored entry starts in the cycle after done, and the pending register clears.
  - Preemption leaves the pending register unchanged.
- SFX_QUEUE_EN, when undefined: non-preempting requests are discarded, and there is no pending register.

## Test plan
- Use DIV_SHIFT=10 and STEP_CYC=400 for all scenarios.
- ev_req=0b0010 pulse from idle -> busy high for 802 cycles; aud_pwm half-period 62 then 55 cycles; done pulse; cur_event=1.
- ev_req=0b1000 playing, then ev_req=0b0001 at cycle 100 -> restart with cur_event=0 at cycle 101; code 7 (49-cycle half-period); no done for ev3.
- ev_req=0b0110 simultaneously -> cur_event=1; ev2 ignored.
- ev_req=0b0001 playing, then ev_req=0b0100 at cycle 50 -> without SFX_QUEUE_EN, ignored and idle after 1604 cycles; with SFX_QUEUE_EN, ev2 starts the cycle after done.
- rst_n low at cycle 300 of ev0 -> all outputs 0 asynchronously; restart only on a new request.
- Request in the done cycle -> new sequence busy one cycle later; busy low for exactly one cycle.

Source files
------------

// File: rtl/sfx_sequencer.sv
// Priority-arbitrated sound-effect sequencer: plays up to four square-wave notes per event.
// Define SFX_QUEUE_EN to keep one dropped request pending until the current sequence ends.
module sfx_sequencer #(
   parameter int unsigned NUM_EVENTS = 8,
   parameter int unsigned STEP_CYC   = 12_500_000,
   parameter int unsigned DIV_SHIFT  = 0
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic [NUM_EVENTS-1:0] ev_req,
   output logic                  aud_pwm,
   output logic                  aud_sd,
   output logic                  busy,
   output logic [3:0]            cur_event,
   output logic                  done
);

   localparam int unsigned SW = $clog2(STEP_CYC);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);

   typedef enum logic [1:0] {IDLE, PLAY, NEXT} state_t;

   state_t        state;
   logic [1:0]    step_idx;
   logic [16:0]   half;
   logic [16:0]   div_cnt;
   logic [SW-1:0] step_cnt;

   logic [3:0] win_idx;
   logic       any_req;
   logic       preempt;
   logic [1:0] nxt_step;
   logic       seq_end;
   logic       start_v;
   logic [3:0] start_idx;
   logic       load;
   logic       go_idle;
   logic [3:0] ld_ev;
   logic [1:0] ld_step;

   function automatic logic [2:0] rom_code(input logic [3:0] ev, input logic [1:0] st);
      logic [11:0] mel;
      logic [2:0]  code;
      case (ev)
         4'd0:    mel = {3'd7, 3'd5, 3'd3, 3'd1};
         4'd1:    mel = {3'd5, 3'd6, 3'd0, 3'd0};
         4'd2:    mel = {3'd5, 3'd6, 3'd7, 3'd7};
         default: mel = {3'd1, 3'd0, 3'd0, 3'd0};
      endcase
      case (st)
         2'd0:    code = mel[11:9];
         2'd1:    code = mel[8:6];
         2'd2:    code = mel[5:3];
         default: code = mel[2:0];
      endcase
      return code;
   endfunction

   function automatic logic [16:0] half_of(input logic [2:0] code);
      logic [16:0] h;
      case (code)
         3'd1:    h = 17'd95547;
         3'd2:    h = 17'd85135;
         3'd3:    h = 17'd75838;
         3'd4:    h = 17'd71581;
         3'd5:    h = 17'd63775;
         3'd6:    h = 17'd56818;
         3'd7:    h = 17'd50617;
         default: h = '0;
      endcase
      return h >> DIV_SHIFT;
   endfunction

   // Lowest set index wins.
   always_comb begin
      win_idx = '0;
      for (int unsigned i = NUM_EVENTS; i > 0; i--)
         if (ev_req[i-1]) win_idx = 4'(i - 1);
   end

   assign any_req  = |ev_req;
   assign preempt  = any_req && (win_idx < cur_event);
   assign nxt_step = step_idx + 2'd1;
   assign seq_end  = (step_idx == 2'd3) || (rom_code(cur_event, nxt_step) == 3'd0);

`ifdef SFX_QUEUE_EN
   logic       pend_v;
   logic [3:0] pend_idx;
   logic       use_pend;
   logic       store_pend;

   // In IDLE the better of pending entry and fresh request starts; the other stays pending.
   assign use_pend   = pend_v && (!any_req || (pend_idx <= win_idx));
   assign start_v    = pend_v || any_req;
   assign start_idx  = use_pend ? pend_idx : win_idx;
   assign store_pend = (state != IDLE) && any_req && !preempt &&
                       (!pend_v || (win_idx < pend_idx));

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         pend_v   <= 1'b0;
         pend_idx <= '0;
      end else if (state == IDLE) begin
         if (use_pend) begin
            pend_v   <= any_req;
            pend_idx <= win_idx;
         end
      end else if (store_pend) begin
         pend_v   <= 1'b1;
         pend_idx <= win_idx;
      end
   end
`else
   assign start_v   = any_req;
   assign start_idx = win_idx;
`endif

   always_comb begin
      load    = 1'b0;
      go_idle = 1'b0;
      ld_ev   = cur_event;
      ld_step = '0;
      case (state)
         IDLE: begin
            if (start_v) begin
               load  = 1'b1;
               ld_ev = start_idx;
            end
         end
         PLAY: begin
            if (preempt) begin
               load  = 1'b1;
               ld_ev = win_idx;
            end
         end
         NEXT: begin
            if (preempt) begin
               load  = 1'b1;
               ld_ev = win_idx;
            end else if (seq_end) begin
               go_idle = 1'b1;
            end else begin
               load    = 1'b1;
               ld_step = nxt_step;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_event <= '0;
         step_idx  <= '0;
         half      <= '0;
         div_cnt   <= '0;
         step_cnt  <= '0;
         aud_pwm   <= 1'b0;
         aud_sd    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            // Every note starts with a fresh phase.
            state     <= PLAY;
            cur_event <= ld_ev;
            step_idx  <= ld_step;
            half      <= half_of(rom_code(ld_ev, ld_step));
            div_cnt   <= '0;
            step_cnt  <= '0;
            aud_pwm   <= 1'b0;
            aud_sd    <= 1'b1;
            busy      <= 1'b1;
         end else if (go_idle) begin
            state   <= IDLE;
            aud_pwm <= 1'b0;
            aud_sd  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
         end else if (state == PLAY) begin
            if (div_cnt == half - 17'd1) begin
               div_cnt <= '0;
               aud_pwm <= ~aud_pwm;
            end else begin
               div_cnt <= div_cnt + 17'd1;
            end
            if (step_cnt == STEP_LAST) state <= NEXT;
            else                       step_cnt <= step_cnt + SW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Randomized bench for sfx_sequencer against a timeline model of sequences (start cycle + offsets).
module tb_sfx_sequencer;

   localparam int NE = 8;
   localparam int S  = 400;
   localparam int DS = 10;

   logic          clk_in = 1'b0;
   logic          rst_n  = 1'b0;
   logic [NE-1:0] ev_req = '0;
   logic          aud_pwm, aud_sd, busy, done;
   logic [3:0]    cur_event;

   sfx_sequencer #(.NUM_EVENTS(NE), .STEP_CYC(S), .DIV_SHIFT(DS)) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .ev_req    (ev_req),
      .aud_pwm   (aud_pwm),
      .aud_sd    (aud_sd),
      .busy      (busy),
      .cur_event (cur_event),
      .done      (done)
   );

   always #5 clk_in = ~clk_in;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle)", tag, got, exp);
      end
   endtask

   int mel_tab [4][4] = '{'{7, 5, 3, 1}, '{5, 6, 0, 0}, '{5, 6, 7, 7}, '{1, 0, 0, 0}};
   int base_half [8]  = '{0, 95547, 85135, 75838, 71581, 63775, 56818, 50617};

   function automatic int code_of(input int ev, input int k);
      if (ev < 4) return mel_tab[ev][k];
      return (k == 0) ? 1 : 0;
   endfunction

   function automatic int half_of(input int code);
      return base_half[code] >> DS;
   endfunction

   function automatic int len_of(input int ev);
      int n;
      n = 0;
      for (int k = 0; k < 4; k++) begin
         if (code_of(ev, k) == 0) break;
         n++;
      end
      return n;
   endfunction

   // Model: a sequence is its event and start cycle; every note spans S+1 cycles.
   int cyc   = 0;
   bit m_act = 0;
   int m_ev  = 0;
   int m_t0  = 0;
   bit m_done = 0;
   bit m_pv  = 0;
   int m_pev = 0;

   task automatic model_edge(input logic [NE-1:0] req);
      int win;
      bit has;
      has = (req != '0);
      win = 0;
      for (int i = NE - 1; i >= 0; i--) if (req[i]) win = i;
      m_done = 0;
      if (!rst_n) begin
         m_act = 0; m_ev = 0; m_pv = 0; m_pev = 0;
         return;
      end
      if (m_act) begin
         if (has && win < m_ev) begin
            m_ev = win; m_t0 = cyc;
         end else begin
`ifdef SFX_QUEUE_EN
            if (has && (!m_pv || win < m_pev)) begin m_pv = 1; m_pev = win; end
`endif
            if (cyc - m_t0 == len_of(m_ev) * (S + 1)) begin m_act = 0; m_done = 1; end
         end
      end else begin
`ifdef SFX_QUEUE_EN
         if (m_pv && (!has || m_pev <= win)) begin
            m_act = 1; m_ev = m_pev; m_t0 = cyc; m_pv = has; m_pev = win;
         end else
`endif
         if (has) begin
            m_act = 1; m_ev = win; m_t0 = cyc;
         end
      end
   endtask

   task automatic compare_outputs();
      int w, k, pos;
      check("busy", busy, m_act);
      check("aud_sd", aud_sd, m_act);
      check("done", done, m_done);
      check("cur_event", cur_event, m_ev);
      if (m_act) begin
         w = cyc - m_t0; k = w / (S + 1); pos = w % (S + 1);
         if (pos < S) check("aud_pwm", aud_pwm, (pos / half_of(code_of(m_ev, k))) % 2);
      end else begin
         check("aud_pwm_idle", aud_pwm, 0);
      end
   endtask

   task automatic step_cycle(input logic [NE-1:0] req);
      ev_req = req;
      @(posedge clk_in);
      cyc++;
      model_edge(req);
      #1;
      ev_req = '0;
      compare_outputs();
   endtask

   int nb;
   bit seen;

   initial begin
      repeat (3) step_cycle('0);
      rst_n = 1'b1;
      repeat (5) step_cycle('0);

      // ev1 alone: two notes, 802 busy cycles
      nb = 0;
      step_cycle(8'b0000_0010); nb += int'(busy);
      repeat (819) begin step_cycle('0); nb += int'(busy); end
      check("busy_len_ev1", nb, 802);

      // ev3 preempted by ev0 at cycle 100
      step_cycle(8'b0000_1000);
      repeat (99) step_cycle('0);
      step_cycle(8'b0000_0001);
      repeat (1700) step_cycle('0);

      // simultaneous ev1+ev2
      step_cycle(8'b0000_0110);
      repeat (900) step_cycle('0);

      // lower-priority request during ev0
      step_cycle(8'b0000_0001);
      repeat (49) step_cycle('0);
      step_cycle(8'b0000_0100);
      repeat (2500) step_cycle('0);

      // asynchronous reset mid-sequence
      step_cycle(8'b0000_0001);
      repeat (299) step_cycle('0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_aud_sd", aud_sd, 0);
      check("rst_aud_pwm", aud_pwm, 0);
      check("rst_cur_event", cur_event, 0);
      check("rst_done", done, 0);
      step_cycle(8'b0000_0001);
      step_cycle('0);
      rst_n = 1'b1;
      repeat (20) step_cycle('0);

      // request in the done cycle
      step_cycle(8'b0000_1000);
      seen = 0;
      for (int i = 0; i < 600 && !seen; i++) begin
         step_cycle('0);
         if (done === 1'b1) seen = 1;
      end
      check("done_seen", seen, 1);
      step_cycle(8'b0000_0010);
      check("restart_busy", busy, 1);
      repeat (900) step_cycle('0);

      // randomized traffic
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 149) == 0) step_cycle(NE'($urandom_range(1, 255)));
         else                             step_cycle('0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
